// File: rtl/rx_pkt_seq.sv
// Receive-packet sequencer: qualifies a BR/EDR packet after the access-code trailer,
// opens the payload window and performs SEQN filtering / ARQN generation.
module rx_pkt_seq #(
    parameter logic [7:0]  HDR_TIMEOUT   = 8'd80,
    parameter logic [12:0] FHS_PYBITS    = 13'd240,
    parameter logic [7:0]  PYLEN_TIMEOUT = 8'd40
) (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic        p_1us,
    input  logic        rx_trailer_st_p,
    input  logic        fhs_mode,
    input  logic        hdr_done_p,
    input  logic        hec_ok,
    input  logic [2:0]  dec_lt_addr,
    input  logic [3:0]  dec_pk_type,
    input  logic        dec_flow,
    input  logic        dec_arqn,
    input  logic        dec_seqn,
    input  logic [2:0]  my_lt_addr,
    input  logic        pylen_valid_p,
    input  logic [12:0] dec_pylenbit,
    input  logic        py_crc_ok,
    input  logic        ack_taken_p,
    output logic        dec_py_period,
    output logic        rx_done_p,
    output logic        rx_err_p,
    output logic [2:0]  rx_errcode,
    output logic        rx_flow,
    output logic        rx_peer_arqn,
    output logic        tx_arqn,
    output logic        last_seqn,
    output logic [2:0]  seq_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_CHK    = 3'd2,
        S_PY_LEN = 3'd3,
        S_PY     = 3'd4,
        S_END    = 3'd5
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [12:0] bit_cnt, bit_cnt_n;
    logic [12:0] pylen, pylen_n;
    logic        h_hec, h_hec_n;
    logic [2:0]  h_lt, h_lt_n;
    logic [3:0]  h_type, h_type_n;
    logic        h_flow, h_flow_n;
    logic        h_arqn, h_arqn_n;
    logic        h_seqn, h_seqn_n;
    logic        done_n, err_n;
    logic [2:0]  code_n;
    logic        flow_n, peer_arqn_n, tx_arqn_n, last_seqn_n;
    logic        is_null;

    assign is_null       = (h_type[3:1] == 3'b000);
    assign dec_py_period = (state == S_PY_LEN) || (state == S_PY);
    assign seq_state     = state;

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            pylen        <= '0;
            h_hec        <= 1'b0;
            h_lt         <= '0;
            h_type       <= '0;
            h_flow       <= 1'b0;
            h_arqn       <= 1'b0;
            h_seqn       <= 1'b0;
            rx_done_p    <= 1'b0;
            rx_err_p     <= 1'b0;
            rx_errcode   <= '0;
            rx_flow      <= 1'b0;
            rx_peer_arqn <= 1'b0;
            tx_arqn      <= 1'b0;
            last_seqn    <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            pylen        <= pylen_n;
            h_hec        <= h_hec_n;
            h_lt         <= h_lt_n;
            h_type       <= h_type_n;
            h_flow       <= h_flow_n;
            h_arqn       <= h_arqn_n;
            h_seqn       <= h_seqn_n;
            rx_done_p    <= done_n;
            rx_err_p     <= err_n;
            rx_errcode   <= code_n;
            rx_flow      <= flow_n;
            rx_peer_arqn <= peer_arqn_n;
            tx_arqn      <= tx_arqn_n;
            last_seqn    <= last_seqn_n;
        end
    end

    // ack_taken_p is applied first so that an ARQN set in END overrides it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        pylen_n     = pylen;
        h_hec_n     = h_hec;
        h_lt_n      = h_lt;
        h_type_n    = h_type;
        h_flow_n    = h_flow;
        h_arqn_n    = h_arqn;
        h_seqn_n    = h_seqn;
        done_n      = 1'b0;
        err_n       = 1'b0;
        code_n      = rx_errcode;
        flow_n      = rx_flow;
        peer_arqn_n = rx_peer_arqn;
        tx_arqn_n   = ack_taken_p ? 1'b0 : tx_arqn;
        last_seqn_n = last_seqn;

        case (state)
            S_IDLE: begin
                if (rx_trailer_st_p) begin
                    state_n = S_HDR;
                    cnt_n   = '0;
                end
            end
            S_HDR: begin
                if (hdr_done_p) begin
                    state_n  = S_CHK;
                    h_hec_n  = hec_ok;
                    h_lt_n   = dec_lt_addr;
                    h_type_n = dec_pk_type;
                    h_flow_n = dec_flow;
                    h_arqn_n = dec_arqn;
                    h_seqn_n = dec_seqn;
                end else if (cnt == HDR_TIMEOUT) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = 3'd3;
                end else if (p_1us) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_CHK: begin
                if (!h_hec) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = 3'd1;
                end else if (!fhs_mode && (h_lt != my_lt_addr) && (h_lt != 3'd0)) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = 3'd2;
                end else begin
                    flow_n      = h_flow;
                    peer_arqn_n = h_arqn;
                    if (is_null) begin
                        state_n = S_END;
                    end else if ((h_type == 4'b0010) || fhs_mode) begin
                        state_n   = S_PY;
                        pylen_n   = FHS_PYBITS;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = S_PY_LEN;
                        cnt_n   = '0;
                    end
                end
            end
            S_PY_LEN: begin
                if (pylen_valid_p) begin
                    pylen_n   = dec_pylenbit;
                    bit_cnt_n = '0;
                    state_n   = (dec_pylenbit == 13'd0) ? S_END : S_PY;
                end else if (cnt == PYLEN_TIMEOUT) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = 3'd6;
                end else if (p_1us) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_PY: begin
                if (p_1us) begin
                    if (bit_cnt == pylen - 13'd1) state_n = S_END;
                    else                          bit_cnt_n = bit_cnt + 13'd1;
                end
            end
            S_END: begin
                state_n = S_IDLE;
                if (is_null) begin
                    done_n = 1'b1;
                    code_n = 3'd0;
                end else if (!py_crc_ok) begin
                    err_n     = 1'b1;
                    code_n    = 3'd4;
                    tx_arqn_n = 1'b0;
                end else if ((h_lt != 3'd0) && !fhs_mode) begin
                    tx_arqn_n = 1'b1;
                    if (h_seqn != last_seqn) begin
                        last_seqn_n = h_seqn;
                        done_n      = 1'b1;
                        code_n      = 3'd0;
                    end else begin
                        err_n  = 1'b1;
                        code_n = 3'd5;
                    end
                end else begin
                    done_n = 1'b1;
                    code_n = 3'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_pkt_seq.sv
// Directed self-checking bench for rx_pkt_seq; one task per scenario.
module tb_rx_pkt_seq;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic        p_1us;
    logic        rx_trailer_st_p;
    logic        fhs_mode;
    logic        hdr_done_p;
    logic        hec_ok;
    logic [2:0]  dec_lt_addr;
    logic [3:0]  dec_pk_type;
    logic        dec_flow;
    logic        dec_arqn;
    logic        dec_seqn;
    logic [2:0]  my_lt_addr;
    logic        pylen_valid_p;
    logic [12:0] dec_pylenbit;
    logic        py_crc_ok;
    logic        ack_taken_p;
    logic        dec_py_period;
    logic        rx_done_p;
    logic        rx_err_p;
    logic [2:0]  rx_errcode;
    logic        rx_flow;
    logic        rx_peer_arqn;
    logic        tx_arqn;
    logic        last_seqn;
    logic [2:0]  seq_state;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int py_ticks = 0;
    int py_high = 0;

    rx_pkt_seq dut (
        .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .rx_trailer_st_p(rx_trailer_st_p),
        .fhs_mode(fhs_mode), .hdr_done_p(hdr_done_p), .hec_ok(hec_ok),
        .dec_lt_addr(dec_lt_addr), .dec_pk_type(dec_pk_type), .dec_flow(dec_flow),
        .dec_arqn(dec_arqn), .dec_seqn(dec_seqn), .my_lt_addr(my_lt_addr),
        .pylen_valid_p(pylen_valid_p), .dec_pylenbit(dec_pylenbit), .py_crc_ok(py_crc_ok),
        .ack_taken_p(ack_taken_p), .dec_py_period(dec_py_period), .rx_done_p(rx_done_p),
        .rx_err_p(rx_err_p), .rx_errcode(rx_errcode), .rx_flow(rx_flow),
        .rx_peer_arqn(rx_peer_arqn), .tx_arqn(tx_arqn), .last_seqn(last_seqn),
        .seq_state(seq_state)
    );

    always #5 clk_6M = ~clk_6M;

    // Cumulative event counters; scenarios compare deltas against a snapshot.
    always @(negedge clk_6M) begin
        if (rx_done_p) done_cnt = done_cnt + 1;
        if (rx_err_p) err_cnt = err_cnt + 1;
        if (dec_py_period) py_high = py_high + 1;
        if (dec_py_period && p_1us) py_ticks = py_ticks + 1;
    end

    task automatic tick();
        p_1us = 1'b1;
        @(posedge clk_6M); #1;
        p_1us = 1'b0;
        @(posedge clk_6M); #1;
        ack_taken_p = 1'b0;
        @(posedge clk_6M); #1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_6M);
        #1;
    endtask

    task automatic send_hdr(input int nticks, input logic hec, input logic [2:0] lt,
                            input logic [3:0] typ, input logic flow, input logic arqn,
                            input logic seqn);
        rx_trailer_st_p = 1'b1;
        wait_clk(1);
        rx_trailer_st_p = 1'b0;
        for (int i = 0; i < nticks; i++) tick();
        hec_ok = hec; dec_lt_addr = lt; dec_pk_type = typ;
        dec_flow = flow; dec_arqn = arqn; dec_seqn = seqn;
        hdr_done_p = 1'b1;
        wait_clk(1);
        hdr_done_p = 1'b0;
    endtask

    task automatic run_payload(input logic has_len, input logic [12:0] len, input int nticks,
                               input logic crc, input logic ack_last);
        py_crc_ok = crc;
        wait_clk(1);
        if (has_len) begin
            dec_pylenbit = len;
            pylen_valid_p = 1'b1;
            wait_clk(1);
            pylen_valid_p = 1'b0;
        end
        for (int i = 0; i < nticks; i++) begin
            if (ack_last && i == nticks - 1) ack_taken_p = 1'b1;
            tick();
        end
        wait_clk(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        checks++; if (seq_state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", seq_state); end
        checks++; if (last_seqn !== 1'b1) begin errors++; $display("[TB] FAIL reset_last_seqn: got %0b expected 1", last_seqn); end
        checks++; if ({dec_py_period, rx_done_p, rx_err_p, rx_errcode, rx_flow, rx_peer_arqn, tx_arqn} !== 9'd0)
            begin errors++; $display("[TB] FAIL reset_outputs: got %b expected 000000000", {dec_py_period, rx_done_p, rx_err_p, rx_errcode, rx_flow, rx_peer_arqn, tx_arqn}); end
        rst = 1'b0;
        wait_clk(2);
        checks++; if (seq_state !== 3'd0) begin errors++; $display("[TB] FAIL idle_after_reset: got %0d expected 0", seq_state); end
    endtask

    task automatic test_null();
        int d0 = done_cnt, e0 = err_cnt, h0 = py_high;
        send_hdr(54, 1'b1, 3'd3, 4'b0000, 1'b1, 1'b1, 1'b0);
        wait_clk(3);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL null_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL null_err: got %0d expected 0", err_cnt - e0); end
        checks++; if (py_high - h0 !== 0) begin errors++; $display("[TB] FAIL null_window: got %0d expected 0", py_high - h0); end
        checks++; if ({tx_arqn, last_seqn} !== 2'b01) begin errors++; $display("[TB] FAIL null_arq: got %b expected 01", {tx_arqn, last_seqn}); end
        checks++; if ({rx_flow, rx_peer_arqn} !== 2'b11) begin errors++; $display("[TB] FAIL null_flow_arqn: got %b expected 11", {rx_flow, rx_peer_arqn}); end
    endtask

    task automatic test_dm1_new();
        int d0 = done_cnt, t0 = py_ticks;
        send_hdr(10, 1'b1, 3'd3, 4'b0011, 1'b0, 1'b0, 1'b0);
        run_payload(1'b1, 13'd80, 83, 1'b1, 1'b0);
        checks++; if (py_ticks - t0 !== 80) begin errors++; $display("[TB] FAIL dm1_window_ticks: got %0d expected 80", py_ticks - t0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL dm1_done: got %0d expected 1", done_cnt - d0); end
        checks++; if ({last_seqn, tx_arqn} !== 2'b01) begin errors++; $display("[TB] FAIL dm1_arq: got %b expected 01", {last_seqn, tx_arqn}); end
        checks++; if ({rx_flow, rx_peer_arqn} !== 2'b00) begin errors++; $display("[TB] FAIL dm1_flow_arqn: got %b expected 00", {rx_flow, rx_peer_arqn}); end
        ack_taken_p = 1'b1;
        wait_clk(1);
        ack_taken_p = 1'b0;
        wait_clk(1);
        checks++; if (tx_arqn !== 1'b0) begin errors++; $display("[TB] FAIL ack_clears: got %0b expected 0", tx_arqn); end
    endtask

    task automatic test_duplicate();
        int d0 = done_cnt, e0 = err_cnt;
        send_hdr(10, 1'b1, 3'd3, 4'b0011, 1'b0, 1'b0, 1'b0);
        run_payload(1'b1, 13'd80, 83, 1'b1, 1'b0);
        checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("[TB] FAIL dup_pulses: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0); end
        checks++; if (rx_errcode !== 3'd5) begin errors++; $display("[TB] FAIL dup_code: got %0d expected 5", rx_errcode); end
        checks++; if ({tx_arqn, last_seqn} !== 2'b10) begin errors++; $display("[TB] FAIL dup_arq: got %b expected 10", {tx_arqn, last_seqn}); end
    endtask

    task automatic test_hdr_errors();
        int e0 = err_cnt, h0 = py_high;
        send_hdr(20, 1'b0, 3'd3, 4'b0011, 1'b1, 1'b1, 1'b1);
        wait_clk(3);
        checks++; if (err_cnt - e0 !== 1 || rx_errcode !== 3'd1) begin errors++; $display("[TB] FAIL hec_err: got err=%0d code=%0d expected 1/1", err_cnt - e0, rx_errcode); end
        checks++; if (py_high - h0 !== 0 || rx_flow !== 1'b0) begin errors++; $display("[TB] FAIL hec_no_payload: got window=%0d flow=%0b expected 0/0", py_high - h0, rx_flow); end
        e0 = err_cnt;
        send_hdr(20, 1'b1, 3'd5, 4'b0011, 1'b0, 1'b0, 1'b1);
        wait_clk(3);
        checks++; if (err_cnt - e0 !== 1 || rx_errcode !== 3'd2) begin errors++; $display("[TB] FAIL addr_err: got err=%0d code=%0d expected 1/2", err_cnt - e0, rx_errcode); end
    endtask

    task automatic test_broadcast();
        int d0 = done_cnt;
        send_hdr(20, 1'b1, 3'd0, 4'b0011, 1'b0, 1'b0, 1'b1);
        run_payload(1'b1, 13'd16, 19, 1'b1, 1'b0);
        checks++; if (done_cnt - d0 !== 1 || rx_errcode !== 3'd0) begin errors++; $display("[TB] FAIL bcast_done: got done=%0d code=%0d expected 1/0", done_cnt - d0, rx_errcode); end
        checks++; if ({tx_arqn, last_seqn} !== 2'b10) begin errors++; $display("[TB] FAIL bcast_arq_untouched: got %b expected 10", {tx_arqn, last_seqn}); end
    endtask

    task automatic test_crc_error();
        int e0 = err_cnt;
        send_hdr(20, 1'b1, 3'd3, 4'b0011, 1'b0, 1'b0, 1'b1);
        run_payload(1'b1, 13'd8, 11, 1'b0, 1'b0);
        checks++; if (err_cnt - e0 !== 1 || rx_errcode !== 3'd4) begin errors++; $display("[TB] FAIL crc_err: got err=%0d code=%0d expected 1/4", err_cnt - e0, rx_errcode); end
        checks++; if ({tx_arqn, last_seqn} !== 2'b00) begin errors++; $display("[TB] FAIL crc_nak: got %b expected 00", {tx_arqn, last_seqn}); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        send_hdr(20, 1'b1, 3'd3, 4'b0011, 1'b1, 1'b0, 1'b1);
        run_payload(1'b1, 13'd8, 8, 1'b1, 1'b1);
        checks++; if ({tx_arqn, last_seqn} !== 2'b11) begin errors++; $display("[TB] FAIL set_wins_over_ack: got %b expected 11", {tx_arqn, last_seqn}); end
        send_hdr(5, 1'b1, 3'd3, 4'b0001, 1'b0, 1'b1, 1'b0);
        wait_clk(3);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("[TB] FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
        checks++; if ({last_seqn, rx_flow, rx_peer_arqn} !== 3'b101) begin errors++; $display("[TB] FAIL poll_fields: got %b expected 101", {last_seqn, rx_flow, rx_peer_arqn}); end
    endtask

    task automatic test_fhs();
        int d0 = done_cnt, t0 = py_ticks;
        fhs_mode = 1'b1;
        send_hdr(30, 1'b1, 3'd6, 4'b0010, 1'b0, 1'b0, 1'b1);
        run_payload(1'b0, 13'd0, 243, 1'b1, 1'b0);
        fhs_mode = 1'b0;
        checks++; if (py_ticks - t0 !== 240) begin errors++; $display("[TB] FAIL fhs_window_ticks: got %0d expected 240", py_ticks - t0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL fhs_done: got %0d expected 1", done_cnt - d0); end
        checks++; if ({tx_arqn, last_seqn} !== 2'b11) begin errors++; $display("[TB] FAIL fhs_arq_untouched: got %b expected 11", {tx_arqn, last_seqn}); end
    endtask

    task automatic test_hdr_timeout();
        int e0 = err_cnt;
        rx_trailer_st_p = 1'b1;
        wait_clk(1);
        rx_trailer_st_p = 1'b0;
        for (int i = 0; i < 79; i++) tick();
        checks++; if (seq_state !== 3'd1 || err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL hdr_before_timeout: got state=%0d err=%0d expected 1/0", seq_state, err_cnt - e0); end
        tick();
        wait_clk(2);
        checks++; if (err_cnt - e0 !== 1 || rx_errcode !== 3'd3 || seq_state !== 3'd0)
            begin errors++; $display("[TB] FAIL hdr_timeout: got err=%0d code=%0d state=%0d expected 1/3/0", err_cnt - e0, rx_errcode, seq_state); end
    endtask

    task automatic test_pylen_timeout();
        int e0 = err_cnt;
        send_hdr(5, 1'b1, 3'd3, 4'b0100, 1'b0, 1'b0, 1'b0);
        wait_clk(1);
        for (int i = 0; i < 39; i++) tick();
        checks++; if (seq_state !== 3'd3 || dec_py_period !== 1'b1) begin errors++; $display("[TB] FAIL pylen_wait: got state=%0d window=%0b expected 3/1", seq_state, dec_py_period); end
        tick();
        wait_clk(2);
        checks++; if (err_cnt - e0 !== 1 || rx_errcode !== 3'd6 || seq_state !== 3'd0)
            begin errors++; $display("[TB] FAIL pylen_timeout: got err=%0d code=%0d state=%0d expected 1/6/0", err_cnt - e0, rx_errcode, seq_state); end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt, e0 = err_cnt;
        send_hdr(5, 1'b1, 3'd3, 4'b0011, 1'b0, 1'b0, 1'b0);
        wait_clk(1);
        dec_pylenbit = 13'd80;
        pylen_valid_p = 1'b1;
        wait_clk(1);
        pylen_valid_p = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (seq_state !== 3'd4 || dec_py_period !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_py: got state=%0d window=%0b expected 4/1", seq_state, dec_py_period); end
        rst = 1'b1;
        #1;
        checks++; if (dec_py_period !== 1'b0 || seq_state !== 3'd0) begin errors++; $display("[TB] FAIL mid_async_reset: got window=%0b state=%0d expected 0/0", dec_py_period, seq_state); end
        wait_clk(1);
        rst = 1'b0;
        checks++; if ({tx_arqn, last_seqn, rx_errcode} !== 5'b01000) begin errors++; $display("[TB] FAIL mid_reset_values: got %b expected 01000", {tx_arqn, last_seqn, rx_errcode}); end
        wait_clk(2);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL mid_no_pulse: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); end
        send_hdr(5, 1'b1, 3'd3, 4'b0011, 1'b0, 1'b0, 1'b0);
        run_payload(1'b1, 13'd8, 11, 1'b1, 1'b0);
        checks++; if (done_cnt - d0 !== 1 || {tx_arqn, last_seqn} !== 2'b10)
            begin errors++; $display("[TB] FAIL after_reset_packet: got done=%0d arq=%b expected 1/10", done_cnt - d0, {tx_arqn, last_seqn}); end
    endtask

    initial begin
        rst = 1'b1; p_1us = 1'b0; rx_trailer_st_p = 1'b0; fhs_mode = 1'b0;
        hdr_done_p = 1'b0; hec_ok = 1'b0; dec_lt_addr = 3'd0; dec_pk_type = 4'd0;
        dec_flow = 1'b0; dec_arqn = 1'b0; dec_seqn = 1'b0; my_lt_addr = 3'd3;
        pylen_valid_p = 1'b0; dec_pylenbit = 13'd0; py_crc_ok = 1'b0; ack_taken_p = 1'b0;
        test_reset();
        test_null();
        test_dm1_new();
        test_duplicate();
        test_hdr_errors();
        test_broadcast();
        test_crc_error();
        test_back_to_back();
        test_fhs();
        test_hdr_timeout();
        test_pylen_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_pkt_seq.md
Name: rx_pkt_seq

Overview:
Receive-packet sequencer for the BR/EDR baseband RX path. Starts on access-code trailer detection, tracks header decode completion, and qualifies the packet on HEC, LT_ADDR and packet type. It then sequences the payload window (dec_py_period) and runs ARQ bookkeeping (SEQN filtering, ARQN generation). Sits between the correlator/header decoder and the payload decoder/link controller.

Parameters:
HDR_TIMEOUT, 8'd80, max p_1us ticks from start to hdr_done_p before abort
FHS_PYBITS, 13'd240, FHS on-air payload bits (144 info + 16 CRC, FEC 2/3)
PYLEN_TIMEOUT, 8'd40, max p_1us ticks in PY_LEN waiting for pylen_valid_p

Ports:
clk_6M input 1 6 MHz system clock
rst input 1 asynchronous active-high reset
p_1us input 1 one-cycle 1 MHz tick
rx_trailer_st_p input 1 trailer start pulse (packet start)
fhs_mode input 1 page/inquiry FHS receive; skip LT_ADDR check and ARQ
hdr_done_p input 1 header+HEC finished (payload start pulse)
hec_ok input 1 HEC remainder zero; valid with hdr_done_p
dec_lt_addr input 3 decoded LT_ADDR
dec_pk_type input 4 decoded TYPE
dec_flow input 1 decoded FLOW
dec_arqn input 1 decoded ARQN
dec_seqn input 1 decoded SEQN
my_lt_addr input 3 own LT_ADDR (slave) / addressed LT_ADDR
pylen_valid_p input 1 payload header decoded
dec_pylenbit input 13 payload length in bits, valid with pylen_valid_p
py_crc_ok input 1 payload CRC result, valid at end of payload
ack_taken_p input 1 TX consumed pending ARQN
dec_py_period output 1 payload window to payload decoder
rx_done_p output 1 packet accepted (one clk_6M pulse)
rx_err_p output 1 packet rejected (one pulse)
rx_errcode output 3 0 none,1 HEC,2 addr,3 hdr timeout,4 CRC,5 duplicate,6 pylen timeout
rx_flow output 1 last accepted FLOW
rx_peer_arqn output 1 last accepted peer ARQN
tx_arqn output 1 ARQN to send
last_seqn output 1 SEQN of last new packet
seq_state output 3 FSM state (debug)

Behaviour:
- Reset: state IDLE(0); all outputs 0; last_seqn 1 (first packet SEQN=0 is new); tick counter 0.
- All state advances gated by p_1us except pulse inputs hdr_done_p / pylen_valid_p / ack_taken_p / rx_trailer_st_p, which are sampled on any clk_6M edge where asserted.
- States: IDLE(0), HDR(1), CHK(2), PY_LEN(3), PY(4), END(5).
- IDLE: rx_trailer_st_p -> HDR, counter cleared.
- HDR: counter +1 per p_1us; hdr_done_p -> CHK (registers hec_ok, fields); counter == HDR_TIMEOUT -> IDLE, rx_err_p, code 3.
- CHK (1 clk): !hec_ok -> err code 1. Else !fhs_mode & dec_lt_addr != my_lt_addr & dec_lt_addr != 0 -> err code 2. Else latch rx_flow, rx_peer_arqn. TYPE 0000/0001 (NULL/POLL): -> END, no payload. TYPE 0010 or fhs_mode: pylen = FHS_PYBITS -> PY. Otherwise -> PY_LEN. Error -> IDLE.
- PY_LEN: dec_py_period=1; pylen_valid_p latches dec_pylenbit; 0 -> END, else -> PY. Timeout PYLEN_TIMEOUT -> IDLE, err code 6.
- PY: dec_py_period=1; bit counter (13 bit) +1 per p_1us; at count == pylen -1 on p_1us -> END, dec_py_period drops same edge.
- END (1 clk): payload types: !py_crc_ok -> err code 4, tx_arqn=0 (NAK). CRC ok, lt_addr!=0, !fhs_mode: dec_seqn != last_seqn -> new: last_seqn<=dec_seqn, tx_arqn<=1, rx_done_p; equal -> duplicate: tx_arqn<=1, rx_err_p code 5 (payload dropped). Broadcast (lt_addr 0) or fhs_mode: rx_done_p, ARQ untouched. NULL/POLL: rx_done_p, ARQ untouched. -> IDLE.
- rx_errcode holds until next rx_done_p/rx_err_p.
- ack_taken_p clears tx_arqn; if END sets tx_arqn same cycle, set wins.
- rx_trailer_st_p outside IDLE: ignored (no restart).
- Reset mid-packet: immediate return to reset values; no pulse emitted.

Test Plan:
- Start, hdr_done_p after 54 ticks, hec_ok=1, lt_addr=my, TYPE NULL -> rx_done_p once, dec_py_period never high, tx_arqn unchanged.
- DM1-type TYPE 0011, SEQN 0, pylen 80 bits, CRC ok -> dec_py_period high exactly through 80th tick, rx_done_p, last_seqn=0, tx_arqn=1; ack_taken_p -> tx_arqn=0.
- Repeat same packet SEQN 0 -> rx_err_p, rx_errcode=5, tx_arqn=1, last_seqn stays 0.
- hec_ok=0 -> rx_err_p code 1, no payload window; lt_addr=5 vs my 3 -> code 2; lt_addr 0 accepted, ARQ untouched.
- fhs_mode=1, TYPE 0010 -> payload window 240 ticks, rx_done_p; no hdr_done_p for 80 ticks -> code 3, IDLE.
- Assert rst during PY -> dec_py_period=0, state 0 next edge; subsequent packet processes normally.
